// File: rtl/dmem_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dump_pkg
// Description : Shared types, default parameters and helper functions for
//               the data memory dump controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_dump_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 6;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_READ_LATENCY = 2;

    // Wide enough to hold READ_LATENCY-1 for the largest legal latency (3)
    localparam int unsigned LAT_CNT_WIDTH = 2;

    // Dump controller states, explicitly encoded
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Index width for a counter over n items, never narrower than one bit
    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_dump_controller_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_serializer
// Description : Loads one memory word and presents it LSB-byte first on a
//               valid/ready port; flags acceptance of the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_serializer
    import dmem_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  last_accept
);

    localparam int unsigned BYTES    = bytes_per_word(DATA_WIDTH);
    localparam int unsigned IDX_W    = index_width(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  w_accept;

    assign w_shifted   = r_shift >> 8;
    assign w_accept    = r_tx_valid && tx_ready;
    assign last_accept = w_accept && (r_idx == LAST_IDX);
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;

    // Load a word, then advance one byte per accepted transfer; data holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else if (load) begin
            r_shift    <= word;
            r_idx      <= '0;
            r_tx_data  <= word[7:0];
            r_tx_valid <= 1'b1;
        end else if (w_accept) begin
            if (r_idx == LAST_IDX) begin
                r_tx_valid <= 1'b0;
            end else begin
                r_shift   <= w_shifted;
                r_idx     <= r_idx + 1'b1;
                r_tx_data <= w_shifted[7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_dump_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_dump_controller
// Description : Passes CPU memory signals through when idle; on request it
//               freezes the CPU clock, sweeps the whole data memory and
//               streams every word out byte-wise over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_dump_controller
    import dmem_dump_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic                  project_clock_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic                  wren_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  wren_out,
    output logic                  project_clock_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_RELOAD = LAT_CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST  = '1;

    state_t                   r_state,   w_state_next;
    logic [ADDR_WIDTH-1:0]    r_address, w_address_next;
    logic                     r_wren,    w_wren_next;
    logic                     r_pclk,    w_pclk_next;
    logic                     r_busy,    w_busy_next;
    logic                     r_done,    w_done_next;
    logic [LAT_CNT_WIDTH-1:0] r_lat,     w_lat_next;
    logic                     w_load;
    logic                     w_last_accept;

    assign address_out       = r_address;
    assign wren_out          = r_wren;
    assign project_clock_out = r_pclk;
    assign busy              = r_busy;
    assign done              = r_done;

    word_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .load        (w_load),
        .word        (q_in),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .last_accept (w_last_accept)
    );

    // State and all registered outputs; reset also aborts a dump in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_address <= '0;
            r_wren    <= 1'b0;
            r_pclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lat     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_address <= w_address_next;
            r_wren    <= w_wren_next;
            r_pclk    <= w_pclk_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_lat     <= w_lat_next;
        end
    end

    // Next-state logic: passthrough in idle, address sweep and read wait while dumping
    always_comb begin
        w_state_next   = r_state;
        w_address_next = r_address;
        w_wren_next    = r_wren;
        w_pclk_next    = r_pclk;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_lat_next     = r_lat;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (dump_start) begin
                    w_state_next   = ST_WAIT;
                    w_address_next = '0;
                    w_wren_next    = 1'b0;
                    w_pclk_next    = 1'b0;
                    w_busy_next    = 1'b1;
                    w_lat_next     = LAT_RELOAD;
                end else begin
                    w_address_next = address_in;
                    w_wren_next    = wren_in;
                    w_pclk_next    = project_clock_in;
                    w_busy_next    = 1'b0;
                end
            end
            ST_WAIT: begin
                // q_in is valid for the current address once the counter has run out
                if (r_lat == '0) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SEND;
                end else begin
                    w_lat_next = r_lat - 1'b1;
                end
            end
            ST_SEND: begin
                if (w_last_accept) begin
                    if (r_address == ADDR_LAST) begin
                        w_state_next = ST_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next   = ST_WAIT;
                        w_address_next = r_address + 1'b1;
                        w_lat_next     = LAT_RELOAD;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_dump_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_dump_controller
// Description : Self-checking bench: reset values, idle passthrough table,
//               full dumps against a byte-stream reference, reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_dump_controller #(
    parameter int READ_LATENCY = 2
);

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int NBYTE = DEPTH * (DW / 8);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          dump_start = 1'b0;
    logic          project_clock_in = 1'b0;
    logic [AW-1:0] address_in = '0;
    logic          wren_in = 1'b0;
    logic [DW-1:0] q_in;
    logic [AW-1:0] address_out;
    logic          wren_out;
    logic          project_clock_out;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] golden [DEPTH];
    logic [DW-1:0] pipe   [3];

    always #5 clock = ~clock;

    data_memory_dump_controller #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .dump_start        (dump_start),
        .project_clock_in  (project_clock_in),
        .address_in        (address_in),
        .wren_in           (wren_in),
        .q_in              (q_in),
        .address_out       (address_out),
        .wren_out          (wren_out),
        .project_clock_out (project_clock_out),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .done              (done)
    );

    // Memory model: writes corrupt the word, reads appear READ_LATENCY edges after the address
    always @(posedge clock) begin
        if (wren_out) mem[address_out] <= 32'hDEADBEEF;
        pipe[0] <= mem[address_out];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    always_comb begin
        q_in = mem[address_out];
        if (READ_LATENCY == 2) q_in = pipe[0];
        if (READ_LATENCY == 3) q_in = pipe[1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input bit random_data);
        @(negedge clock);
        for (int k = 0; k < DEPTH; k++) begin
            golden[k] = random_data ? $urandom : (32'hA0B0C000 + k);
            mem[k]   <= golden[k];
        end
        @(negedge clock);
    endtask

    // Runs one dump; the expected stream is every golden word split LSB byte first
    task automatic run_dump(input bit rand_ready, input int abort_after);
        logic [7:0] q[$];
        logic [7:0] prev_data;
        logic       prev_valid;
        logic       prev_acc;
        logic       acc;
        int         cyc;
        int         first_valid;
        int         ndone;
        int         nbytes;
        int         nbad;
        bit         finished;
        prev_data   = 8'h00;
        prev_valid  = 1'b0;
        prev_acc    = 1'b0;
        cyc         = 0;
        first_valid = -1;
        ndone       = 0;
        nbytes      = 0;
        finished    = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            for (int b = 0; b < DW / 8; b++)
                q.push_back(8'((golden[k] >> (8 * b)) & 32'hFF));

        @(negedge clock);
        dump_start       = 1'b1;
        wren_in          = 1'b1;
        address_in       = 6'h3F;
        project_clock_in = 1'b1;
        tx_ready         = 1'b0;

        while (!finished && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            dump_start = (cyc > 1) ? 1'(rand_ready & $urandom_range(0, 1)) : 1'b0;
            if (cyc == 1) begin
                check("start_busy", busy, 1'b1);
                check("start_addr", address_out, 6'h00);
            end
            if (busy) begin
                check("dump_wren_low", wren_out, 1'b0);
                check("dump_pclk_low", project_clock_out, 1'b0);
            end
            if (tx_valid && first_valid < 0) begin
                first_valid = cyc;
                check("first_valid_cycle", cyc, READ_LATENCY + 1);
            end
            if (prev_valid && !prev_acc) begin
                check("hold_valid", tx_valid, 1'b1);
                check("hold_data", tx_data, prev_data);
            end
            if (done) begin
                ndone++;
                finished         = 1'b1;
                dump_start       = 1'b0;
                wren_in          = 1'b0;
                address_in       = '0;
                project_clock_in = 1'b0;
            end
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = tx_valid && tx_ready;
            if (acc) begin
                if (q.size() == 0) begin
                    check("extra_byte", 1'b1, 1'b0);
                end else begin
                    check("byte", tx_data, q.pop_front());
                end
                nbytes++;
            end
            prev_valid = tx_valid;
            prev_acc   = acc;
            prev_data  = tx_data;
            if (abort_after > 0 && nbytes == abort_after && acc) begin
                @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check("abort_valid", tx_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                reset      = 1'b0;
                dump_start = 1'b0;
                wren_in    = 1'b0;
                tx_ready   = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    check("abort_no_done", done, 1'b0);
                end
                return;
            end
        end

        check("dump_finished", finished, 1'b1);
        @(negedge clock);
        check("after_busy", busy, 1'b0);
        check("after_done", done, 1'b0);
        check("done_pulses", ndone, 1);
        check("byte_count", nbytes, NBYTE);
        nbad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== golden[k]) nbad++;
        check("mem_intact", nbad, 0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          wren;
        logic          pclk;
        logic [AW-1:0] exp_addr;
        logic          exp_wren;
        logic          exp_pclk;
    } pt_vec_t;

    pt_vec_t vecs [6];

    initial begin
        logic [AW-1:0] pa;
        logic          pw;
        logic          pp;

        vecs[0] = '{6'h15, 1'b1, 1'b1, 6'h15, 1'b1, 1'b1};
        vecs[1] = '{6'h15, 1'b1, 1'b0, 6'h15, 1'b1, 1'b0};
        vecs[2] = '{6'h15, 1'b1, 1'b1, 6'h15, 1'b1, 1'b1};
        vecs[3] = '{6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0};
        vecs[4] = '{6'h3F, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0};
        vecs[5] = '{6'h2A, 1'b0, 1'b1, 6'h2A, 1'b0, 1'b1};

        // Reset values with busy-looking inputs applied
        address_in       = 6'h2A;
        wren_in          = 1'b1;
        project_clock_in = 1'b1;
        tx_ready         = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_addr", address_out, 6'h00);
        check("rst_wren", wren_out, 1'b0);
        check("rst_pclk", project_clock_out, 1'b0);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset    = 1'b0;
        tx_ready = 1'b0;

        // Idle passthrough table: outputs follow inputs one edge later
        for (int i = 0; i < 6; i++) begin
            address_in       = vecs[i].addr;
            wren_in          = vecs[i].wren;
            project_clock_in = vecs[i].pclk;
            tx_ready         = 1'(i & 1);
            @(negedge clock);
            check("pt_addr", address_out, vecs[i].exp_addr);
            check("pt_wren", wren_out, vecs[i].exp_wren);
            check("pt_pclk", project_clock_out, vecs[i].exp_pclk);
            check("pt_busy", busy, 1'b0);
            check("pt_valid", tx_valid, 1'b0);
        end

        // Random idle passthrough
        for (int i = 0; i < 20; i++) begin
            pa = AW'($urandom);
            pw = 1'($urandom);
            pp = 1'($urandom);
            address_in       = pa;
            wren_in          = pw;
            project_clock_in = pp;
            @(negedge clock);
            check("rpt_addr", address_out, pa);
            check("rpt_wren", wren_out, pw);
            check("rpt_pclk", project_clock_out, pp);
        end
        wren_in          = 1'b0;
        project_clock_in = 1'b0;
        address_in       = '0;
        @(negedge clock);

        preload(1'b0);
        run_dump(1'b0, 0);
        repeat (2) @(negedge clock);
        run_dump(1'b1, 0);
        repeat (2) @(negedge clock);
        run_dump(1'b0, 10);
        run_dump(1'b0, 0);
        preload(1'b1);
        run_dump(1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/data_memory_dump_controller.md
Name: data_memory_dump_controller

Overview:
- Reads back the in-use data memory and streams it out byte-wise over a valid/ready port, e.g. to the UART/debug link.
- Sits in front of the same data-memory port as the reset controller and passes CPU address/wren/project clock through when idle.
- During a dump it freezes the CPU by holding project_clock_out low, forces wren_out low, and sweeps addresses 0..2^ADDR_WIDTH-1.

Parameters:
ADDR_WIDTH, 6, data memory address width; depth = 2^ADDR_WIDTH words
DATA_WIDTH, 32, data memory word width; must be a multiple of 8
READ_LATENCY, 2, edges from registered address_out to valid q_in (1..3 legal)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
dump_start  input  1  request a full-memory dump; sampled only in IDLE
project_clock_in  input  1  CPU clock from clock divider
address_in  input  ADDR_WIDTH  CPU data address
wren_in  input  1  CPU write enable
q_in  input  DATA_WIDTH  data memory read data
address_out  output  ADDR_WIDTH  address to data memory
wren_out  output  1  write enable to data memory
project_clock_out  output  1  gated CPU clock
tx_data  output  8  dump byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts byte
busy  output  1  dump in progress
done  output  1  one-cycle pulse after final byte accepted

Behaviour:
- Reset: state IDLE; address_out=0, wren_out=0, project_clock_out=0, tx_data=0, tx_valid=0, busy=0, done=0, byte index 0, latency counter 0. Reset mid-dump aborts: next edge tx_valid=0 and busy=0, with no done pulse.
- All outputs are registered.
- IDLE:
  - Registered passthrough with 1-cycle latency: address_out<=address_in, wren_out<=wren_in, project_clock_out<=project_clock_in.
  - tx_valid=0, busy=0.
- Start: dump_start=1 at edge E0 in IDLE. At E0:
  - busy<=1, address_out<=0, wren_out<=0, project_clock_out<=0.
  - Latency counter loads READ_LATENCY-1; state WAIT.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0 (E0+READ_LATENCY for word 0), capture q_in into the shift register, tx_data<=q_in[7:0], tx_valid<=1, byte index 0; state SEND.
- SEND:
  - A transfer occurs at an edge with tx_valid&&tx_ready. tx_data and tx_valid must hold stable until then.
  - Byte order is little-endian: bits [7:0] first, then [15:8], and so on, up to DATA_WIDTH/8 bytes.
  - On a transfer of a non-last byte: tx_data<=next byte, tx_valid stays 1. tx_ready held high gives 1 byte/cycle.
  - On a transfer of the last byte, tx_valid<=0, then:
    - If address_out is not all-ones: address_out<=address_out+1, counter reload, state WAIT.
    - If address_out is all-ones: state DONE.
- DONE: done=1 for exactly one cycle, busy<=0; state IDLE. Passthrough resumes on the following edge.
- Throughout the dump: wren_out=0 and project_clock_out=0. project_clock_in, address_in, wren_in and dump_start are ignored. Memory is never written.
- Address arithmetic: no wrap inside a dump; exactly 2^ADDR_WIDTH words and 2^ADDR_WIDTH*DATA_WIDTH/8 bytes (256 at defaults).
- tx_ready high while tx_valid=0 has no effect.
- dump_start held high through DONE starts a new dump only from IDLE, i.e. on the edge after done.

Decomposition:
- Package dmem_dump_pkg:
  - state enum {IDLE, WAIT, SEND, DONE}
  - BYTES_PER_WORD = DATA_WIDTH/8
  - localparams derived from ADDR_WIDTH/DATA_WIDTH
- One sub-module, word_byte_serializer: loads a word, presents bytes LSB-first under valid/ready, signals last-byte accept.
- FSM, latency counter, address counter and passthrough muxing stay in the top module.

Test Plan:
- Preload mem[k]=32'hA0B0C000+k; pulse dump_start; tx_ready=1 constantly -> 256 bytes in order 00,C0,B0,A0,01,C0,B0,A0,... ending 3F,C0,B0,A0; done pulses once; busy low after.
- Same dump with tx_ready toggling pseudo-randomly -> identical byte stream; tx_data never changes while tx_valid=1 and tx_ready=0.
- Idle passthrough: address_in=6'h15, wren_in=1, project_clock_in toggling -> outputs equal inputs one edge later; busy=0, tx_valid=0.
- During dump drive wren_in=1, address_in=6'h3F, project_clock_in=1 -> wren_out=0 and project_clock_out=0 for the whole dump; memory contents unchanged afterwards.
- Assert reset after 10 bytes -> next edge tx_valid=0, busy=0, no done pulse; a subsequent dump_start restarts at word 0, byte 00.
- READ_LATENCY=1 and 3 builds, with first tx_valid checked at E0+READ_LATENCY -> correct data each, no stale word 0 bytes.
